// File: rtl/mem_arbiter_pkg.sv
// Shared LC-3b memory types used by the arbiter and its command latches.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_A = 2'd1,
        SERV_B = 2'd2,
        RESP   = 2'd3
    } lc3b_arb_state;

endpackage

// File: rtl/arb_cmd_latch.sv
// Per-port command register: holds address, byte mask, write data, write flag, pending bit.
// Latency: loaded fields appear one cycle after load_i; clr_i drops pending on the next edge.
// Backpressure: none; load_i has priority over clr_i.
// Ports: clk/rst_n; load_i, clr_i controls; req_i/write_i/wmask_i/address_i/wdata_i command in;
//        pend_o/write_o/wmask_o/address_o/wdata_o latched command out.
module arb_cmd_latch
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic             req_i,
    input  logic             write_i,
    input  lc3b_mem_wmask    wmask_i,
    input  logic [15:0]      address_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             pend_o,
    output logic             write_o,
    output lc3b_mem_wmask    wmask_o,
    output logic [15:0]      address_o,
    output logic [WIDTH-1:0] wdata_o
);

    logic             pend_q, pend_d;
    logic             write_q, write_d;
    lc3b_mem_wmask    wmask_q, wmask_d;
    logic [15:0]      address_q, address_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    always_comb begin
        pend_d    = pend_q;
        write_d   = write_q;
        wmask_d   = wmask_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        if (load_i) begin
            pend_d    = req_i;
            write_d   = write_i;
            wmask_d   = wmask_i;
            address_d = address_i;
            wdata_d   = wdata_i;
        end else if (clr_i) begin
            pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            write_q   <= 1'b0;
            wmask_q   <= '0;
            address_q <= '0;
            wdata_q   <= '0;
        end else begin
            pend_q    <= pend_d;
            write_q   <= write_d;
            wmask_q   <= wmask_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
        end
    end

    assign pend_o    = pend_q;
    assign write_o   = write_q;
    assign wmask_o   = wmask_q;
    assign address_o = address_q;
    assign wdata_o   = wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises datapath ports A (instr, read-only) and B (data, r/w) onto one physical memory port.
// Latency: strobe one cycle after the batch is sampled; one joint RESP cycle after the last pmem_resp.
// Backpressure: requests are level-held until resp; new requests are only sampled in IDLE.
// Ports: a_* port A, b_* port B, pmem_* physical memory; clk with synchronous active-low rst_n.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit PRIORITY_B = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_read,
    input  logic [15:0]      a_address,
    output logic [WIDTH-1:0] a_rdata,
    output logic             a_resp,
    input  logic             b_read,
    input  logic             b_write,
    input  logic [1:0]       b_wmask,
    input  logic [15:0]      b_address,
    input  logic [WIDTH-1:0] b_wdata,
    output logic [WIDTH-1:0] b_rdata,
    output logic             b_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [1:0]       pmem_wmask,
    output logic [15:0]      pmem_address,
    output logic [WIDTH-1:0] pmem_wdata,
    input  logic [WIDTH-1:0] pmem_rdata,
    input  logic             pmem_resp
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SERV_A = SERV_A;
    localparam logic [1:0] ST_SERV_B = SERV_B;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]       state_q, state_d;
    logic             inc_a_q, inc_a_d, inc_b_q, inc_b_d;
    logic [WIDTH-1:0] a_buf_q, a_buf_d, b_buf_q, b_buf_d;

    logic             a_req, b_req, load, clr_a, clr_b;
    logic             a_pend, a_wr, b_pend, b_wr;
    lc3b_mem_wmask    a_mask, b_mask;
    logic [15:0]      a_addr, b_addr;
    logic [WIDTH-1:0] a_wd, b_wd;

    assign a_req = a_read;
    assign b_req = b_read | b_write;
    assign load  = (state_q == ST_IDLE) && (a_req || b_req);
    assign clr_a = (state_q == ST_SERV_A) && pmem_resp;
    assign clr_b = (state_q == ST_SERV_B) && pmem_resp;

    // Port A is latched as a full-word read so its pmem fields come from registers like B's.
    arb_cmd_latch #(.WIDTH(WIDTH)) u_cmd_a (
        .clk(clk), .rst_n(rst_n), .load_i(load), .clr_i(clr_a),
        .req_i(a_req), .write_i(1'b0), .wmask_i(2'b11),
        .address_i(a_address), .wdata_i('0),
        .pend_o(a_pend), .write_o(a_wr), .wmask_o(a_mask),
        .address_o(a_addr), .wdata_o(a_wd)
    );

    arb_cmd_latch #(.WIDTH(WIDTH)) u_cmd_b (
        .clk(clk), .rst_n(rst_n), .load_i(load), .clr_i(clr_b),
        .req_i(b_req), .write_i(b_write), .wmask_i(b_wmask),
        .address_i(b_address), .wdata_i(b_wdata),
        .pend_o(b_pend), .write_o(b_wr), .wmask_o(b_mask),
        .address_o(b_addr), .wdata_o(b_wd)
    );

    always_comb begin
        state_d = state_q;
        inc_a_d = inc_a_q;
        inc_b_d = inc_b_q;
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    // Remember batch membership: pending bits clear as each port is served.
                    inc_a_d = a_req;
                    inc_b_d = b_req;
                    if (PRIORITY_B) state_d = b_req ? ST_SERV_B : ST_SERV_A;
                    else            state_d = a_req ? ST_SERV_A : ST_SERV_B;
                end
            end
            ST_SERV_A: begin
                if (pmem_resp) begin
                    if (!a_wr) a_buf_d = pmem_rdata;
                    state_d = b_pend ? ST_SERV_B : ST_RESP;
                end
            end
            ST_SERV_B: begin
                if (pmem_resp) begin
                    if (!b_wr) b_buf_d = pmem_rdata;
                    state_d = a_pend ? ST_SERV_A : ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            inc_a_q <= 1'b0;
            inc_b_q <= 1'b0;
            a_buf_q <= '0;
            b_buf_q <= '0;
        end else begin
            state_q <= state_d;
            inc_a_q <= inc_a_d;
            inc_b_q <= inc_b_d;
            a_buf_q <= a_buf_d;
            b_buf_q <= b_buf_d;
        end
    end

    // Physical port is driven only from latched commands and only in a SERV state.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wmask   = '0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state_q == ST_SERV_A) begin
            pmem_read    = !a_wr;
            pmem_write   = a_wr;
            pmem_wmask   = a_mask;
            pmem_address = a_addr;
            pmem_wdata   = a_wd;
        end else if (state_q == ST_SERV_B) begin
            pmem_read    = !b_wr;
            pmem_write   = b_wr;
            pmem_wmask   = b_mask;
            pmem_address = b_addr;
            pmem_wdata   = b_wd;
        end
    end

    assign a_resp  = (state_q == ST_RESP) && inc_a_q;
    assign b_resp  = (state_q == ST_RESP) && inc_b_q;
    assign a_rdata = a_buf_q;
    assign b_rdata = b_buf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_read;
    logic [15:0] a_address;
    logic [15:0] a_rdata;
    logic        a_resp;
    logic        b_read, b_write;
    logic [1:0]  b_wmask;
    logic [15:0] b_address, b_wdata, b_rdata;
    logic        b_resp;
    logic        pmem_read, pmem_write;
    logic [1:0]  pmem_wmask;
    logic [15:0] pmem_address, pmem_wdata, pmem_rdata;
    logic        pmem_resp;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  m;
        logic [15:0] ad;
        logic [15:0] wd;
    } xact_t;

    xact_t       log_q[$];
    logic [15:0] rdq[$];
    int          lat;
    int          cnt;

    mem_arbiter #(.WIDTH(16), .PRIORITY_B(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_read(a_read), .a_address(a_address), .a_rdata(a_rdata), .a_resp(a_resp),
        .b_read(b_read), .b_write(b_write), .b_wmask(b_wmask), .b_address(b_address),
        .b_wdata(b_wdata), .b_rdata(b_rdata), .b_resp(b_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Physical memory: answers lat negedges into a strobe window, logs every transaction.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        cnt        = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || pmem_resp) begin
                pmem_resp = 1'b0;
                cnt       = 0;
            end else if (pmem_read || pmem_write) begin
                cnt++;
                if (cnt >= lat) begin
                    pmem_resp = 1'b1;
                    log_q.push_back('{pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata});
                    if (pmem_read) pmem_rdata = (rdq.size() > 0) ? rdq.pop_front() : 16'h0000;
                    else           pmem_rdata = 16'hDEAD;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Waits (bounded) for a response cycle; returns negedges elapsed.
    task automatic wait_resp(input string tag, output int n);
        bit seen = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            n++;
            check({tag, "_excl"}, {31'd0, pmem_read & pmem_write}, 32'd0);
            if (a_resp || b_resp) seen = 1'b1;
        end
        check({tag, "_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_nostrobe"}, {30'd0, pmem_read, pmem_write}, 32'd0);
    endtask

    initial begin
        int n;
        int resps;
        rst_n = 1'b0; a_read = 1'b0; a_address = '0;
        b_read = 1'b0; b_write = 1'b0; b_wmask = '0; b_address = '0; b_wdata = '0;
        lat = 2;
        repeat (2) @(negedge clk);
        check("rst_resp",  {30'd0, a_resp, b_resp}, 32'd0);
        check("rst_pmem",  {30'd0, pmem_read, pmem_write}, 32'd0);
        check("rst_addr",  pmem_address, 32'd0);
        check("rst_rdata", {a_rdata, b_rdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_quiet", {30'd0, pmem_read, pmem_write}, 32'd0);

        // A only
        rdq.push_back(16'h1234);
        a_read = 1'b1; a_address = 16'h0040;
        wait_resp("t1", n);
        check("t1_lat", n, 32'd3);
        check("t1_resp", {30'd0, a_resp, b_resp}, 32'd2);
        check("t1_rdata", a_rdata, 32'h1234);
        a_read = 1'b0;
        check("t1_nx", log_q.size(), 32'd1);
        if (log_q.size() == 1) begin
            check("t1_addr", log_q[0].ad, 32'h0040);
            check("t1_rw", {30'd0, log_q[0].rd, log_q[0].wr}, 32'd2);
            check("t1_mask", log_q[0].m, 32'd3);
        end
        log_q.delete();
        @(negedge clk);
        check("t1_pulse", {30'd0, a_resp, b_resp}, 32'd0);

        // A+B read, B first; B address changes mid-service
        rdq.push_back(16'hAAAA); rdq.push_back(16'hBBBB);
        a_read = 1'b1; a_address = 16'h0010;
        b_read = 1'b1; b_address = 16'h0200;
        @(negedge clk);
        check("t2_first", {15'd0, pmem_read, pmem_address}, 32'h1_0200);
        b_address = 16'hFFFF;
        @(negedge clk);
        check("t2_stable", pmem_address, 32'h0200);
        wait_resp("t2", n);
        check("t2_resp", {30'd0, a_resp, b_resp}, 32'd3);
        check("t2_ard", a_rdata, 32'hBBBB);
        check("t2_brd", b_rdata, 32'hAAAA);
        a_read = 1'b0; b_read = 1'b0;
        check("t2_nx", log_q.size(), 32'd2);
        if (log_q.size() == 2) begin
            check("t2_ord0", log_q[0].ad, 32'h0200);
            check("t2_ord1", log_q[1].ad, 32'h0010);
        end
        log_q.delete();
        @(negedge clk);
        check("t2_pulse", {30'd0, a_resp, b_resp}, 32'd0);

        // B write
        b_write = 1'b1; b_wmask = 2'b01; b_address = 16'h0301; b_wdata = 16'h00EF;
        wait_resp("t3", n);
        check("t3_resp", {30'd0, a_resp, b_resp}, 32'd1);
        check("t3_brd", b_rdata, 32'hAAAA);
        b_write = 1'b0;
        check("t3_nx", log_q.size(), 32'd1);
        if (log_q.size() == 1) begin
            check("t3_rw", {30'd0, log_q[0].rd, log_q[0].wr}, 32'd1);
            check("t3_addr", log_q[0].ad, 32'h0301);
            check("t3_mask", log_q[0].m, 32'd1);
            check("t3_wd", log_q[0].wd, 32'h00EF);
        end
        log_q.delete();
        @(negedge clk);

        // Late B arrival during an A-only batch
        rdq.push_back(16'h5555); rdq.push_back(16'h6666);
        a_read = 1'b1; a_address = 16'h0050;
        @(negedge clk);
        b_read = 1'b1; b_address = 16'h0060;
        wait_resp("t4a", n);
        check("t4a_resp", {30'd0, a_resp, b_resp}, 32'd2);
        check("t4a_ard", a_rdata, 32'h5555);
        a_read = 1'b0;
        @(negedge clk);
        check("t4_bubble", {30'd0, pmem_read, pmem_write}, 32'd0);
        @(negedge clk);
        check("t4b_serv", {15'd0, pmem_read, pmem_address}, 32'h1_0060);
        wait_resp("t4b", n);
        check("t4b_resp", {30'd0, a_resp, b_resp}, 32'd1);
        check("t4b_rd", {b_rdata, a_rdata}, 32'h6666_5555);
        b_read = 1'b0;
        log_q.delete();
        @(negedge clk);

        // Reset in the middle of SERV_A
        lat = 5;
        a_read = 1'b1; a_address = 16'h0070;
        @(negedge clk);
        @(negedge clk);
        check("t5_serv", pmem_read, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_drop", {30'd0, pmem_read, pmem_write}, 32'd0);
        check("t5_noresp", {30'd0, a_resp, b_resp}, 32'd0);
        check("t5_bufs", {a_rdata, b_rdata}, 32'd0);
        rst_n = 1'b1; a_read = 1'b0;
        resps = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_resp || b_resp || pmem_read || pmem_write) resps++;
        end
        check("t5_quiet", resps, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
